// File: rtl/lock_sequencer_if.sv
// Bundle between the debounced switch/button front end and lock_sequencer.
// The PROGRAM_EN macro adds the prog qualifier; without it the signal does not exist.
//
// Handshake: there is no valid/ready pair on this bus. enter is a one-cycle
// strobe that qualifies sw in that cycle only. clear is a one-cycle abort
// strobe. The sequencer is always able to take a strobe: strobes that arrive
// while it is OPEN or LOCKOUT are dropped, never stalled.
interface lock_sequencer_if;
    logic [5:0] sw;
    logic       enter;
    logic       clear;
`ifdef PROGRAM_EN
    logic       prog;
`endif
    logic       unlock;
    logic       alarm;
    logic [3:0] fail_cnt;
    logic [2:0] entry_cnt;
    logic [1:0] state_dbg;

    // Front end / bench side
    modport master (
        output sw, enter, clear,
`ifdef PROGRAM_EN
        output prog,
`endif
        input  unlock, alarm, fail_cnt, entry_cnt, state_dbg
    );

    // Sequencer side
    modport slave (
        input  sw, enter, clear,
`ifdef PROGRAM_EN
        input  prog,
`endif
        output unlock, alarm, fail_cnt, entry_cnt, state_dbg
    );
endinterface

// File: rtl/lock_sequencer.sv
// Combination-lock sequencer: collects CODE_LEN switch words, opens the door for
// OPEN_CYC cycles on a full match, counts failed sequences and raises a timed
// alarm lockout after MAX_TRIES failures.
// Optional feature macro PROGRAM_EN: the code lives in registers that can be
// rewritten while OPEN (enter with prog=1).
// The default CODE packs entry 0 in the low 6 bits, so the entry order is 2A, 3A, 2B.
module lock_sequencer #(
    parameter int                    CODE_LEN    = 3,
    parameter logic [6*CODE_LEN-1:0] CODE        = {6'h2B, 6'h3A, 6'h2A},
    parameter int                    MAX_TRIES   = 3,
    parameter int                    OPEN_CYC    = 8,
    parameter int                    LOCKOUT_CYC = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    lock_sequencer_if.slave  bus
);

    localparam int TMAX = (OPEN_CYC > LOCKOUT_CYC) ? OPEN_CYC : LOCKOUT_CYC;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        OPEN    = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [3:0]      fail_cnt_q, fail_cnt_d;
    logic [2:0]      entry_cnt_q, entry_cnt_d;
    logic            miss_q, miss_d;
    logic            unlock_q, unlock_d;
    logic            alarm_q, alarm_d;

    // Code table indexed by the 3-bit entry counter; slots past CODE_LEN are never read.
    logic [5:0]      code_tab [8];
    logic [5:0]      code_slot;
    logic            hit;
    logic            last_entry;

`ifdef PROGRAM_EN
    logic [5:0]      code_q [CODE_LEN];
    logic [5:0]      code_d [CODE_LEN];
    logic [2:0]      wr_idx_q, wr_idx_d;

    // Expose the programmable code registers as the lookup table
    always_comb begin
        for (int i = 0; i < 8; i++) code_tab[i] = 6'd0;
        for (int i = 0; i < CODE_LEN; i++) code_tab[i] = code_q[i];
    end
`else
    // Fixed code: the table is the CODE parameter split into 6-bit slots
    always_comb begin
        for (int i = 0; i < 8; i++) code_tab[i] = 6'd0;
        for (int i = 0; i < CODE_LEN; i++) code_tab[i] = CODE[6*i +: 6];
    end
`endif

    assign code_slot  = code_tab[entry_cnt_q];
    assign hit        = (bus.sw == code_slot);
    assign last_entry = (entry_cnt_q == 3'(CODE_LEN - 1));

    // Next-state logic for the sequencer, its timer, counters and registered outputs
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        fail_cnt_d  = fail_cnt_q;
        entry_cnt_d = entry_cnt_q;
        miss_d      = miss_q;
`ifdef PROGRAM_EN
        code_d      = code_q;
        wr_idx_d    = wr_idx_q;
`endif

        case (state_q)
            IDLE, COLLECT: begin
                if (bus.clear) begin
                    // Abort wins over a simultaneous enter; failure count is kept.
                    entry_cnt_d = 3'd0;
                    miss_d      = 1'b0;
                    state_d     = IDLE;
                end else if (bus.enter) begin
                    if (last_entry) begin
                        entry_cnt_d = 3'd0;
                        miss_d      = 1'b0;
                        if (!miss_q && hit) begin
                            state_d    = OPEN;
                            timer_d    = TW'(OPEN_CYC);
                            fail_cnt_d = 4'd0;
`ifdef PROGRAM_EN
                            wr_idx_d   = 3'd0;
`endif
                        end else if (({1'b0, fail_cnt_q} + 5'd1) < 5'(MAX_TRIES)) begin
                            state_d    = IDLE;
                            fail_cnt_d = fail_cnt_q + 4'd1;
                        end else begin
                            state_d    = LOCKOUT;
                            timer_d    = TW'(LOCKOUT_CYC);
                            fail_cnt_d = 4'(MAX_TRIES);
                        end
                    end else begin
                        // No early reject: a wrong entry is only remembered.
                        entry_cnt_d = entry_cnt_q + 3'd1;
                        miss_d      = miss_q | ~hit;
                        state_d     = COLLECT;
                    end
                end
            end

            OPEN: begin
`ifdef PROGRAM_EN
                if (bus.enter && bus.prog) begin
                    // Overwrite one slot and keep the door open for a full period again.
                    for (int i = 0; i < CODE_LEN; i++) begin
                        if (wr_idx_q == 3'(i)) code_d[i] = bus.sw;
                    end
                    if (wr_idx_q != 3'(CODE_LEN - 1)) wr_idx_d = wr_idx_q + 3'd1;
                    timer_d = TW'(OPEN_CYC);
                end else
`endif
                if (timer_q == TW'(1)) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end

            LOCKOUT: begin
                // Strobes are ignored here, including on the exit cycle.
                if (timer_q == TW'(1)) begin
                    state_d    = IDLE;
                    fail_cnt_d = 4'd0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end

            default: state_d = IDLE;
        endcase

        unlock_d = (state_d == OPEN);
        alarm_d  = (state_d == LOCKOUT);
    end

    // State, counters and output registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            fail_cnt_q  <= 4'd0;
            entry_cnt_q <= 3'd0;
            miss_q      <= 1'b0;
            unlock_q    <= 1'b0;
            alarm_q     <= 1'b0;
`ifdef PROGRAM_EN
            wr_idx_q    <= 3'd0;
            for (int i = 0; i < CODE_LEN; i++) code_q[i] <= CODE[6*i +: 6];
`endif
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            fail_cnt_q  <= fail_cnt_d;
            entry_cnt_q <= entry_cnt_d;
            miss_q      <= miss_d;
            unlock_q    <= unlock_d;
            alarm_q     <= alarm_d;
`ifdef PROGRAM_EN
            wr_idx_q    <= wr_idx_d;
            code_q      <= code_d;
`endif
        end
    end

    assign bus.unlock    = unlock_q;
    assign bus.alarm     = alarm_q;
    assign bus.fail_cnt  = fail_cnt_q;
    assign bus.entry_cnt = entry_cnt_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Testbench for lock_sequencer: directed scenarios plus random strobes, checked
// against a sequence-level model (entry list, remaining open/lockout cycles).
module tb_lock_sequencer;

    localparam int LEN       = 3;
    localparam int MAX_TRIES = 3;
    localparam int OPEN_CYC  = 8;
    localparam int LOCK_CYC  = 16;
    localparam int W         = 9;   // {unlock, alarm, fail_cnt[3:0], entry_cnt[2:0]}
`ifdef PROGRAM_EN
    localparam bit PROG_BUILD = 1'b1;
`else
    localparam bit PROG_BUILD = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lock_sequencer_if bus();

    lock_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    logic [5:0] m_code [LEN];
    logic [5:0] m_entries[$];
    int m_fails;
    int m_open;   // cycles of unlock still to show
    int m_lock;   // cycles of alarm still to show
    int m_wr;

    function automatic void model_reset();
        m_code[0] = 6'h2A;
        m_code[1] = 6'h3A;
        m_code[2] = 6'h2B;
        m_entries.delete();
        m_fails = 0;
        m_open  = 0;
        m_lock  = 0;
        m_wr    = 0;
    endfunction

    function automatic logic [W-1:0] model_step(logic en, logic cl, logic [5:0] s, logic pr);
        bit ok;
        if (m_open > 0) begin
            if (PROG_BUILD && en && pr) begin
                m_code[m_wr] = s;
                if (m_wr < LEN - 1) m_wr++;
                m_open = OPEN_CYC;
            end else begin
                m_open--;
            end
        end else if (m_lock > 0) begin
            m_lock--;
            if (m_lock == 0) m_fails = 0;
        end else if (cl) begin
            m_entries.delete();
        end else if (en) begin
            m_entries.push_back(s);
            if (m_entries.size() == LEN) begin
                ok = 1'b1;
                for (int i = 0; i < LEN; i++) if (m_entries[i] != m_code[i]) ok = 1'b0;
                m_entries.delete();
                if (ok) begin
                    m_open  = OPEN_CYC;
                    m_fails = 0;
                    m_wr    = 0;
                end else if (m_fails + 1 < MAX_TRIES) begin
                    m_fails++;
                end else begin
                    m_fails = MAX_TRIES;
                    m_lock  = LOCK_CYC;
                end
            end
        end
        return {m_open > 0, m_lock > 0, 4'(m_fails), 3'(m_entries.size())};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step(input logic en, input logic cl, input logic [5:0] s, input logic pr);
        @(negedge clk);
        bus.enter = en;
        bus.clear = cl;
        bus.sw    = s;
`ifdef PROGRAM_EN
        bus.prog  = pr;
`endif
        exp_q.push_back(model_step(en, cl, s, pr));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 6'($urandom), 1'b0);
    endtask

    task automatic seq3(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
        step(1'b1, 1'b0, a, 1'b0);
        step(1'b1, 1'b0, b, 1'b0);
        step(1'b1, 1'b0, c, 1'b0);
    endtask

    task automatic check_reset_outputs(input string name);
        logic [W-1:0] act;
        act = {bus.unlock, bus.alarm, bus.fail_cnt, bus.entry_cnt};
        checks++;
        if (act !== '0) begin
            errors++;
            $display("FAIL %s: got unlock=%0b alarm=%0b fail_cnt=%0d entry_cnt=%0d, expected all zero",
                     name, act[8], act[7], act[6:3], act[2:0]);
        end
    endtask

    // Asynchronous reset in the middle of a cycle, checked before any clock edge.
    task automatic async_reset(input string name);
        @(posedge clk);
        #3;
        rst_n     = 1'b0;
        bus.enter = 1'b0;
        bus.clear = 1'b0;
        #1;
        check_reset_outputs(name);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [W-1:0] exp;
        logic [W-1:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                act = {bus.unlock, bus.alarm, bus.fail_cnt, bus.entry_cnt};
                checks++;
                if (act !== exp) begin
                    errors++;
                    $display("FAIL outputs @%0t: got unlock=%0b alarm=%0b fail_cnt=%0d entry_cnt=%0d, expected unlock=%0b alarm=%0b fail_cnt=%0d entry_cnt=%0d",
                             $time, act[8], act[7], act[6:3], act[2:0],
                             exp[8], exp[7], exp[6:3], exp[2:0]);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic en, cl, pr;
        logic [5:0] s;

        bus.sw    = 6'd0;
        bus.enter = 1'b0;
        bus.clear = 1'b0;
`ifdef PROGRAM_EN
        bus.prog  = 1'b0;
`endif
        model_reset();
        #12;
        check_reset_outputs("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // Good sequence, then strobes during OPEN are ignored
        seq3(6'h2A, 6'h3A, 6'h2B);
        step(1'b1, 1'b0, 6'h2A, 1'b0);
        step(1'b0, 1'b1, 6'h00, 1'b0);
        idle(OPEN_CYC + 2);

        // One bad sequence (wrong middle entry is not rejected early)
        seq3(6'h2A, 6'h00, 6'h2B);
        idle(2);

        // Two more bad sequences reach lockout; enter held through the whole lockout
        seq3(6'h01, 6'h3A, 6'h2B);
        seq3(6'h2A, 6'h3A, 6'h2C);
        for (int i = 0; i < LOCK_CYC; i++) step(1'b1, 1'b0, 6'h2A, 1'b0);
        idle(1);
        seq3(6'h2A, 6'h3A, 6'h2B);
        idle(OPEN_CYC + 1);

        // clear beats a simultaneous enter; sequence still works afterwards
        step(1'b1, 1'b0, 6'h2A, 1'b0);
        step(1'b1, 1'b1, 6'h3A, 1'b0);
        seq3(6'h2A, 6'h3A, 6'h2B);
        idle(OPEN_CYC + 1);

        // Partial bad entries then clear keep fail_cnt; reset mid-OPEN and mid-LOCKOUT
        seq3(6'h00, 6'h00, 6'h00);
        step(1'b1, 1'b0, 6'h00, 1'b0);
        step(1'b0, 1'b1, 6'h00, 1'b0);
        seq3(6'h2A, 6'h3A, 6'h2B);
        idle(2);
        async_reset("reset_in_open");
        idle(2);
        seq3(6'h00, 6'h3A, 6'h2B);
        seq3(6'h00, 6'h3A, 6'h2B);
        seq3(6'h00, 6'h3A, 6'h2B);
        idle(5);
        async_reset("reset_in_lockout");
        seq3(6'h2A, 6'h3A, 6'h2B);
        idle(OPEN_CYC + 1);

        // Reprogramming in OPEN (a fourth write overwrites the last slot)
        seq3(6'h2A, 6'h3A, 6'h2B);
        step(1'b1, 1'b0, 6'h01, 1'b1);
        step(1'b1, 1'b0, 6'h02, 1'b1);
        step(1'b1, 1'b0, 6'h07, 1'b1);
        step(1'b1, 1'b0, 6'h03, 1'b1);
        idle(OPEN_CYC + 1);
        seq3(6'h2A, 6'h3A, 6'h2B);
        seq3(6'h01, 6'h02, 6'h03);
        idle(OPEN_CYC + 1);

        // Random strobes, biased toward correct code words
        for (int i = 0; i < 800; i++) begin
            en = ($urandom_range(0, 2) == 0);
            cl = ($urandom_range(0, 15) == 0);
            pr = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) != 0 && m_entries.size() < LEN)
                s = m_code[m_entries.size()];
            else
                s = 6'($urandom);
            step(en, cl, s, pr);
        end
        idle(2);

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d expected entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
